// File: rtl/mmm_seq_pkg.sv
// Shared types and helpers for the sequential Montgomery multiplier.
// The optional operand check is enabled with the MMM_SEQ_OPCHECK_EN macro.
package mmm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Iteration counter width; a single bit still suffices when n_bits is 2.
  function automatic int cnt_width(input int n_bits);
    return (n_bits <= 2) ? 1 : $clog2(n_bits);
  endfunction

endpackage

// File: rtl/mmm_iteration.sv
// One radix-2 Montgomery step: s_o = (s_i + a_bit*b + q*n) / 2, with q
// chosen so the sum is even. Purely combinational.
module mmm_iteration
  import mmm_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N:0]   s_i,
  input  logic         a_bit_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] n_i,
  output logic [N:0]   s_o
);

  logic [N+1:0] t1_s;
  logic [N+1:0] t2_s;
  logic         q_s;

  // s stays below 2n, so s + b + n fits in N+2 bits before the halving.
  always_comb begin
    t1_s = {1'b0, s_i} + (a_bit_i ? {2'b00, b_i} : {(N+2){1'b0}});
    q_s  = t1_s[0];
    t2_s = t1_s + (q_s ? {2'b00, n_i} : {(N+2){1'b0}});
    s_o  = t2_s[N+1:1];
  end

endmodule

// File: rtl/mmm_seq.sv
// Sequential Montgomery multiplier: y = a*b*2^-N mod n over N+2 busy cycles.
// Defining MMM_SEQ_OPCHECK_EN adds a registered operand-check flag on err.
module mmm_seq
  import mmm_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         err
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] n_q, n_d;
  logic [N-1:0] y_q, y_d;
  logic [N:0]   s_q, s_d;
  logic [N:0]   s_next_s;
  logic [N:0]   s_diff_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         accept_s;

  mmm_iteration #(.N(N)) u_iter (
    .s_i     (s_q),
    .a_bit_i (a_q[0]),
    .b_i     (b_q),
    .n_i     (n_q),
    .s_o     (s_next_s)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept_s  = in_valid && in_ready;
  assign y         = y_q;

  // Next-state and datapath register updates; everything holds by default.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    s_diff_s = s_q - {1'b0, n_q};
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          s_d     = {(N+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d   = s_next_s;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = FINAL;
        end else begin
          state_d = RUN;
        end
      end
      FINAL: begin
        y_d     = (s_q >= {1'b0, n_q}) ? s_diff_s[N-1:0] : s_q[N-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      n_q     <= {N{1'b0}};
      y_q     <= {N{1'b0}};
      s_q     <= {(N+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      y_q     <= y_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MMM_SEQ_OPCHECK_EN
  logic err_q, err_d;

  // Flag an even modulus or an operand that is not reduced, captured on accept.
  always_comb begin
    if (accept_s) begin
      err_d = (n[0] == 1'b0) || (a >= n) || (b >= n);
    end else begin
      err_d = err_q;
    end
  end

  // Operand-check flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mmm_seq.sv
// Scoreboard bench for mmm_seq: an N=8 lane for directed cases and reset,
// an N=32 lane for randomized back-to-back operations.
module tb_mmm_seq;

  typedef struct {
    logic [31:0] y;
    logic        err;
    logic        chk_y;
    longint      acc;
  } exp_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     ncmp = 0;
  int     nerr = 0;

  logic        rst_n     [2];
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [31:0] a_s [2];
  logic [31:0] b_s [2];
  logic [31:0] n_s [2];
  logic        ir_s  [2];
  logic        ov_s  [2];
  logic        err_s [2];
  logic [31:0] y_s   [2];
  bit          bp5   [2];

  logic [7:0]  y8;
  logic [31:0] y32;
  logic        ir8, ov8, er8, ir32, ov32, er32;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmm_seq #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(ir8),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .n(n_s[0][7:0]),
    .out_valid(ov8), .out_ready(out_ready[0]), .y(y8), .err(er8)
  );

  mmm_seq #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(ir32),
    .a(a_s[1]), .b(b_s[1]), .n(n_s[1]),
    .out_valid(ov32), .out_ready(out_ready[1]), .y(y32), .err(er32)
  );

  assign ir_s[0]  = ir8;
  assign ov_s[0]  = ov8;
  assign err_s[0] = er8;
  assign y_s[0]   = {24'd0, y8};
  assign ir_s[1]  = ir32;
  assign ov_s[1]  = ov32;
  assign err_s[1] = er32;
  assign y_s[1]   = y32;

  function automatic int lane_w(input int l);
    return (l == 0) ? 8 : 32;
  endfunction

  // a*b*2^-w mod n: reduce the product, then halve modulo n w times.
  function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] n, input int w);
    longint unsigned r;
    longint unsigned nn;
    nn = {32'd0, n};
    r  = ({32'd0, a} * {32'd0, b}) % nn;
    for (int i = 0; i < w; i++) begin
      r = (r[0] == 1'b1) ? ((r + nn) >> 1) : (r >> 1);
    end
    return r[31:0];
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] n);
`ifdef MMM_SEQ_OPCHECK_EN
    return (n[0] == 1'b0) || (a >= n) || (b >= n);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int qsize(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int l);
    exp_t e;
    if (l == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    return e;
  endfunction

  task automatic chk_reset(input int l);
    ncmp++;
    if (ov_s[l] !== 1'b0 || ir_s[l] !== 1'b1 || y_s[l] !== 32'd0 || err_s[l] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state lane %0d: got ov=%b ir=%b y=%0d err=%b, required ov=0 ir=1 y=0 err=0",
               l, ov_s[l], ir_s[l], y_s[l], err_s[l]);
    end
  endtask

  task automatic do_op(input int l, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] n, input bit push_it, input bit chk);
    int t;
    exp_t e;
    logic [31:0] msk;
    msk = (l == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    @(negedge clk);
    t = 0;
    while (!ir_s[l] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!ir_s[l]) begin
      ncmp++;
      nerr++;
      $display("FAIL accept_timeout lane %0d: in_ready got 0, required 1", l);
    end else begin
      a_s[l] = a;
      b_s[l] = b;
      n_s[l] = n;
      in_valid[l] = 1'b1;
      e.y     = ref_y(a, b, n, lane_w(l));
      e.err   = exp_err(a, b, n);
      e.chk_y = chk;
      e.acc   = cyc + 1;
      if (push_it) begin
        if (l == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      @(negedge clk);
      ncmp++;
      if (err_s[l] !== e.err) begin
        nerr++;
        $display("FAIL err_after_accept lane %0d: got %b, required %b", l, err_s[l], e.err);
      end
      // Garbage on the inputs while busy must not disturb the latched operands.
      a_s[l] = $urandom & msk;
      b_s[l] = $urandom & msk;
      n_s[l] = $urandom & msk;
      @(negedge clk);
      in_valid[l] = 1'b0;
    end
  endtask

  task automatic mon(input int l);
    logic        pov = 1'b0;
    logic        por = 1'b0;
    logic [31:0] hy  = 32'd0;
    int          wn  = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n[l]) begin
        pov = 1'b0;
        por = 1'b0;
        out_ready[l] = 1'b0;
      end else begin
        if (pov && por) begin
          ncmp++;
          if (ov_s[l] || !ir_s[l]) begin
            nerr++;
            $display("FAIL idle_after_handshake lane %0d: got ov=%b ir=%b, required ov=0 ir=1",
                     l, ov_s[l], ir_s[l]);
          end
        end
        if (pov && !por) begin
          ncmp++;
          if (!ov_s[l] || y_s[l] !== hy || ir_s[l]) begin
            nerr++;
            $display("FAIL hold_under_backpressure lane %0d: got ov=%b y=%0d ir=%b, required ov=1 y=%0d ir=0",
                     l, ov_s[l], y_s[l], ir_s[l], hy);
          end
        end else if (ov_s[l]) begin
          if (qsize(l) == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL unexpected_out lane %0d: got out_valid=1, required 0", l);
          end else begin
            e = qpop(l);
            if (e.chk_y) begin
              ncmp++;
              if (y_s[l] !== e.y) begin
                nerr++;
                $display("FAIL y lane %0d: got %0d, required %0d", l, y_s[l], e.y);
              end
            end
            ncmp++;
            if (err_s[l] !== e.err) begin
              nerr++;
              $display("FAIL err lane %0d: got %b, required %b", l, err_s[l], e.err);
            end
            ncmp++;
            if (cyc != e.acc + lane_w(l) + 1) begin
              nerr++;
              $display("FAIL latency lane %0d: got %0d edges, required %0d",
                       l, cyc - e.acc, lane_w(l) + 1);
            end
            ncmp++;
            if (ir_s[l]) begin
              nerr++;
              $display("FAIL in_ready_in_done lane %0d: got 1, required 0", l);
            end
          end
          hy = y_s[l];
          wn = bp5[l] ? 5 : int'($urandom_range(0, 2));
          bp5[l] = 1'b0;
        end
        if (ov_s[l]) begin
          if (wn > 0) begin
            out_ready[l] = 1'b0;
            wn--;
          end else begin
            out_ready[l] = 1'b1;
          end
        end else begin
          out_ready[l] = 1'($urandom_range(0, 1));
        end
        pov = ov_s[l];
        por = out_ready[l];
      end
    end
  endtask

  initial begin
    int t;
    logic [31:0] ra, rb, rn;
    for (int l = 0; l < 2; l++) begin
      rst_n[l] = 1'b0;
      in_valid[l] = 1'b0;
      out_ready[l] = 1'b0;
      a_s[l] = 32'd0;
      b_s[l] = 32'd0;
      n_s[l] = 32'd0;
      bp5[l] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      mon(0);
      mon(1);
    join_none

    fork
      begin
        bp5[0] = 1'b1;
        do_op(0, 32'd5, 32'd7, 32'd13, 1'b1, 1'b1);
        do_op(0, 32'd1, 32'd1, 32'd13, 1'b1, 1'b1);
        do_op(0, 32'd0, 32'd12, 32'd13, 1'b1, 1'b1);
        do_op(0, 32'd5, 32'd7, 32'd12, 1'b1, 1'b0);
        do_op(0, 32'd13, 32'd5, 32'd13, 1'b1, 1'b1);
        do_op(0, 32'd1, 32'd1, 32'd13, 1'b1, 1'b1);
        // Abandon an operation mid-run; it must never produce a result.
        do_op(0, 32'd5, 32'd7, 32'd13, 1'b0, 1'b1);
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        do_op(0, 32'd5, 32'd7, 32'd13, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
          rn = ($urandom & 32'h0000_00FF) | 32'd1;
          ra = $urandom % rn;
          rb = $urandom % rn;
          do_op(0, ra, rb, rn, 1'b1, 1'b1);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          rn = $urandom | 32'd1;
          ra = $urandom % rn;
          rb = $urandom % rn;
          do_op(1, ra, rb, rn, 1'b1, 1'b1);
        end
      end
    join

    t = 0;
    while ((qsize(0) != 0 || qsize(1) != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (qsize(0) != 0 || qsize(1) != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: got %0d/%0d results pending, required 0/0", qsize(0), qsize(1));
    end
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
